// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NREQ valid/ready requesters share one FIFO write port.
// Burst ownership is capped at MAX_BURST beats; a credit counter mirrors FIFO free space.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4,
   localparam int IW = $clog2(NREQ),
   localparam int CW = $clog2(DEPTH) + 1,
   localparam int BW = $clog2(MAX_BURST + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    fifo_wr_en,
   output logic [WIDTH-1:0]        fifo_din,
   input  logic                    fifo_full,
   input  logic                    fifo_rd_en,
   input  logic                    fifo_empty,
   output logic [IW-1:0]           grant_id,
   output logic                    busy,
   output logic [CW-1:0]           credits
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_rr_ptr;
   logic [IW-1:0]    r_grant_id;
   logic [BW-1:0]    r_beat_cnt;
   logic [CW-1:0]    r_credits;
   logic             r_busy;
   logic             r_wr_en;
   logic [WIDTH-1:0] r_din;

   logic [IW-1:0]    w_rot_idx [NREQ];
   logic [WIDTH-1:0] w_req_data [NREQ];
   logic             w_can_write;
   logic             w_owner_valid;
   logic             w_accept;
   logic             w_cred_inc;
   logic             w_pick_found;
   logic [IW-1:0]    w_pick_idx;
   logic [IW-1:0]    w_next_ptr;

   // w_rot_idx[k] is the requester k places after rr_ptr, wrapped mod NREQ
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         logic [IW:0] w_sum;
         assign w_sum          = {1'b0, r_rr_ptr} + (IW+1)'(gi);
         assign w_rot_idx[gi]  = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ))
                                                          : w_sum[IW-1:0];
         assign w_req_data[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign w_can_write   = (r_credits != '0) && !fifo_full;
   assign w_owner_valid = req_valid[r_grant_id];
   assign w_accept      = (r_state == GRANT) && w_owner_valid && w_can_write;
   assign w_cred_inc    = fifo_rd_en && !fifo_empty;
   assign w_next_ptr    = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

   // Scan from the farthest offset down so the closest valid requester wins
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[w_rot_idx[k]]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_rot_idx[k];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (r_state == GRANT && w_can_write)
         req_ready[r_grant_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_beat_cnt <= '0;
         r_credits  <= CW'(DEPTH);
         r_busy     <= 1'b0;
         r_wr_en    <= 1'b0;
         r_din      <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept)
            r_din <= w_req_data[r_grant_id];

         if (w_cred_inc && !w_accept)
            r_credits <= r_credits + 1'b1;
         else if (!w_cred_inc && w_accept)
            r_credits <= r_credits - 1'b1;

         case (r_state)
            IDLE: begin
               if (w_pick_found && w_can_write) begin
                  r_state    <= GRANT;
                  r_busy     <= 1'b1;
                  r_grant_id <= w_pick_idx;
                  r_beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (!w_owner_valid) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_rr_ptr <= w_next_ptr;
               end else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (r_beat_cnt == BW'(MAX_BURST - 1)) begin
                     r_state  <= IDLE;
                     r_busy   <= 1'b0;
                     r_rr_ptr <= w_next_ptr;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fifo_wr_en = r_wr_en;
   assign fifo_din   = r_din;
   assign grant_id   = r_grant_id;
   assign busy       = r_busy;
   assign credits    = r_credits;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO, requester streams and a data scoreboard.
module tb_fifo_wr_arbiter;
   localparam int NREQ = 4, WIDTH = 8, DEPTH = 8, MAX_BURST = 4;
   localparam logic [7:0] BASE [NREQ] = '{8'h10, 8'h40, 8'h80, 8'hC0};

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wr_en;
   logic [WIDTH-1:0]      fifo_din;
   logic                  fifo_full;
   logic                  fifo_rd_en = 1'b0;
   logic                  fifo_empty;
   logic [1:0]            grant_id;
   logic                  busy;
   logic [3:0]            credits;

   logic [NREQ-1:0] en = '0;
   int              lim [NREQ];
   int              cnt [NREQ];
   logic [7:0]      fq[$];
   logic [7:0]      exp_q[$];
   int              fcount;
   int              n_tests = 0;
   int              n_fail  = 0;

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .grant_id(grant_id),
      .busy(busy), .credits(credits));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Requester i offers BASE[i]+cnt[i] while enabled and below its beat limit
   always_comb begin
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                = en[i] && (cnt[i] < lim[i]);
         req_data[i*WIDTH +: WIDTH]  = BASE[i] + 8'(cnt[i]);
      end
   end

   assign fifo_full  = (fcount == DEPTH);
   assign fifo_empty = (fcount == 0);

   // Requester handshakes, behavioural FIFO and in-order data scoreboard
   always @(posedge clk or posedge rst) begin
      logic [7:0] got;
      logic [31:0] expd;
      if (rst) begin
         fq.delete();
         exp_q.delete();
         fcount <= 0;
         for (int i = 0; i < NREQ; i++) cnt[i] <= 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back(req_data[i*WIDTH +: WIDTH]);
               cnt[i] <= cnt[i] + 1;
            end
         end
         if (fifo_rd_en && fq.size() != 0) begin
            got  = fq.pop_front();
            expd = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h1FF;
            $display("[TB] pop 0x%02h", got);
            check_val("fifo_data", 32'(got), expd);
         end
         if (fifo_wr_en) begin
            check_val("wr_not_full", 32'(fq.size() >= DEPTH), 0);
            fq.push_back(fifo_din);
         end
         fcount <= fq.size();
      end
   end

   // Credits must equal FIFO free space minus any write still in flight
   always @(negedge clk) begin
      if (!rst) begin
         check_val("cred_bound", 32'(credits <= DEPTH), 1);
         check_val("cred_track", 32'(credits), 32'(DEPTH - fq.size() - int'(fifo_wr_en)));
      end
   end

   task automatic drain();
      int t;
      fifo_rd_en = 1'b1;
      t = 0;
      while (!(fifo_empty && !fifo_wr_en && !busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_val("drain_done", 32'(t < 200), 1);
      repeat (3) begin
         @(negedge clk);
         check_val("empty_rd_cred", 32'(credits), DEPTH);
      end
      fifo_rd_en = 1'b0;
   endtask

   int e_busy [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
   int e_wr   [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   int e_din  [11] = '{0, 'h10, 'h11, 'h12, 'h13, 0, 'h14, 'h15, 'h16, 'h17, 0};
   int e_cred [11] = '{8, 7, 6, 5, 4, 4, 3, 2, 1, 0, 0};
   int e_gnt  [5]  = '{0, 1, 2, 3, 0};

   initial begin
      int g [8];
      int b [8];
      int ng, bc;
      logic pb;
      for (int i = 0; i < NREQ; i++) lim[i] = 0;

      // Reset values
      repeat (2) @(negedge clk);
      check_val("rst_credits", 32'(credits), DEPTH);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_wr_en", 32'(fifo_wr_en), 0);
      check_val("rst_ready", 32'(req_ready), 0);
      check_val("rst_grant", 32'(grant_id), 0);
      check_val("rst_din", 32'(fifo_din), 0);

      // Single requester, no reads: bursts of 4 with one arbitration cycle between
      rst    = 1'b0;
      en     = 4'b0001;
      lim[0] = 10;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         check_val("t1_busy", 32'(busy), e_busy[k]);
         check_val("t1_wr_en", 32'(fifo_wr_en), e_wr[k]);
         if (e_wr[k] != 0) check_val("t1_din", 32'(fifo_din), e_din[k]);
         check_val("t1_credits", 32'(credits), e_cred[k]);
         if (k == 0) check_val("t1_ready", 32'(req_ready), 1);
      end
      repeat (3) @(negedge clk);
      check_val("t1_hold_busy", 32'(busy), 0);
      check_val("t1_hold_ready", 32'(req_ready), 0);
      check_val("t1_hold_cred", 32'(credits), 0);

      // Credit return while an owner is stalled in GRANT
      fifo_rd_en = 1'b1;
      @(negedge clk);
      fifo_rd_en = 1'b0;
      check_val("t4_cred_ret", 32'(credits), 1);
      check_val("t4_idle", 32'(busy), 0);
      @(negedge clk);
      check_val("t4_grant", 32'(busy), 1);
      check_val("t4_ready", 32'(req_ready), 1);
      @(negedge clk);
      check_val("t4_wr18", 32'(fifo_wr_en), 1);
      check_val("t4_din18", 32'(fifo_din), 'h18);
      check_val("t4_stall_ready", 32'(req_ready), 0);
      @(negedge clk);
      check_val("t4_stall_busy", 32'(busy), 1);
      check_val("t4_stall_wr", 32'(fifo_wr_en), 0);
      check_val("t4_stall_ready2", 32'(req_ready), 0);
      fifo_rd_en = 1'b1;
      @(negedge clk);
      fifo_rd_en = 1'b0;
      check_val("t4_cred_1", 32'(credits), 1);
      check_val("t4_ready_again", 32'(req_ready), 1);
      check_val("t4_no_wr_yet", 32'(fifo_wr_en), 0);
      @(negedge clk);
      check_val("t4_wr19", 32'(fifo_wr_en), 1);
      check_val("t4_din19", 32'(fifo_din), 'h19);
      check_val("t4_cred_0", 32'(credits), 0);
      @(negedge clk);
      check_val("t4_release", 32'(busy), 0);
      check_val("t4_wr_done", 32'(fifo_wr_en), 0);
      en = '0;
      drain();

      // Asynchronous reset mid-burst (beat_cnt=2)
      en     = 4'b0010;
      lim[1] = cnt[1] + 8;
      repeat (3) @(negedge clk);
      check_val("t6_busy", 32'(busy), 1);
      check_val("t6_gid", 32'(grant_id), 1);
      check_val("t6_wr", 32'(fifo_wr_en), 1);
      #2 rst = 1'b1;
      #1;
      check_val("t6_async_busy", 32'(busy), 0);
      check_val("t6_async_wr", 32'(fifo_wr_en), 0);
      check_val("t6_async_cred", 32'(credits), DEPTH);
      check_val("t6_async_gid", 32'(grant_id), 0);
      check_val("t6_async_ready", 32'(req_ready), 0);
      check_val("t6_async_din", 32'(fifo_din), 0);
      @(negedge clk);
      @(negedge clk);

      // All four valid, consumer draining every cycle: grants 0,1,2,3,0 of 4 beats
      rst        = 1'b0;
      en         = 4'b1111;
      fifo_rd_en = 1'b1;
      for (int i = 0; i < NREQ; i++) lim[i] = 100;
      for (int i = 0; i < 8; i++) begin g[i] = 'hF; b[i] = 0; end
      ng = 0; bc = 0; pb = 1'b0;
      repeat (26) begin
         @(negedge clk);
         if (busy && !pb) begin
            if (ng > 0 && ng <= 8) b[ng-1] = bc;
            if (ng < 8) g[ng] = int'(grant_id);
            ng++;
            bc = 0;
         end
         bc += int'(fifo_wr_en);
         pb = busy;
      end
      for (int i = 0; i < 5; i++) check_val($sformatf("t2_grant%0d", i), 32'(g[i]), 32'(e_gnt[i]));
      for (int i = 0; i < 4; i++) check_val($sformatf("t2_beats%0d", i), 32'(b[i]), MAX_BURST);
      en = '0;
      drain();

      // Owner drops valid after 2 beats: next grant goes past it
      en     = 4'b0100;
      lim[2] = cnt[2] + 2;
      @(negedge clk);
      check_val("t3_gid2", 32'(grant_id), 2);
      repeat (2) @(negedge clk);
      check_val("t3_busy", 32'(busy), 1);
      check_val("t3_wr", 32'(fifo_wr_en), 1);
      @(negedge clk);
      check_val("t3_release", 32'(busy), 0);
      en     = 4'b1001;
      lim[0] = cnt[0] + 1;
      lim[3] = cnt[3] + 1;
      @(negedge clk);
      check_val("t3_next_busy", 32'(busy), 1);
      check_val("t3_next_gid", 32'(grant_id), 3);
      repeat (6) @(negedge clk);
      en = '0;
      drain();

      // Simultaneous accept and read at credits=5
      en     = 4'b0001;
      lim[0] = cnt[0] + 6;
      repeat (4) @(negedge clk);
      check_val("t5_cred5", 32'(credits), 5);
      fifo_rd_en = 1'b1;
      @(negedge clk);
      fifo_rd_en = 1'b0;
      check_val("t5_cred_hold", 32'(credits), 5);
      check_val("t5_release", 32'(busy), 0);
      repeat (6) @(negedge clk);
      en = '0;
      drain();
      check_val("sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
